// File: rtl/latch_bank_pkg.sv
// Shared types, default sizes and the word-enable decode used by the
// latch-bank write controller.
package latch_bank_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    OPEN  = 3'd2,
    HOLD  = 3'd3,
    CLEAR = 3'd4,
    RECOV = 3'd5
  } lbc_state_e;

  localparam int unsigned LBC_NWORDS     = 16;
  localparam int unsigned LBC_WIDTH      = 8;
  localparam int unsigned LBC_CLR_CYCLES = 2;
  localparam int unsigned LBC_MAX_WORDS  = 1024;

  // One-hot word enable; an address beyond the bank yields no enable at all.
  function automatic logic [LBC_MAX_WORDS-1:0] word_onehot(input logic [31:0] addr,
                                                           input int unsigned nwords);
    logic [LBC_MAX_WORDS-1:0] oh;
    oh = '0;
    if (addr < nwords) begin
      oh[addr[9:0]] = 1'b1;
    end else begin
      oh = '0;
    end
    return oh;
  endfunction

endpackage

// File: rtl/latch_bank_wr_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins, contention goes
// to the requester that was not served last.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic       last_grant_r;
  logic [1:0] gnt_s;

  // Grant decode from the request pair and the last winner.
  always_comb begin
    gnt_s = 2'b00;
    if (!en) begin
      gnt_s = 2'b00;
    end else if (req == 2'b11) begin
      gnt_s = last_grant_r ? 2'b01 : 2'b10;
    end else begin
      gnt_s = req;
    end
  end

  assign gnt = gnt_s;

  // Last-winner flop; resetting to 1 lets req0 win the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_r <= 1'b1;
    end else if (en && (|req)) begin
      last_grant_r <= gnt_s[1];
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

endmodule

// File: rtl/latch_bank_wr_ctrl.sv
// Write sequencer for a latch-based register bank: arbitrates two writers,
// runs setup/open/hold around each latch enable and issues bank clears.
module latch_bank_wr_ctrl
  import latch_bank_pkg::*;
#(
  parameter int unsigned NWORDS     = LBC_NWORDS,
  parameter int unsigned WIDTH      = LBC_WIDTH,
  parameter int unsigned AW         = $clog2(NWORDS),
  parameter int unsigned CLR_CYCLES = LBC_CLR_CYCLES
) (
  input  logic              CLK,
  input  logic              RSTB,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [AW-1:0]     req0_addr,
  input  logic [WIDTH-1:0]  req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [AW-1:0]     req1_addr,
  input  logic [WIDTH-1:0]  req1_data,
  input  logic              clr_req,
  output logic              clr_ack,
  output logic [NWORDS-1:0] lat_en,
  output logic [WIDTH-1:0]  lat_d,
  output logic              lat_rstb,
  output logic              busy,
  output logic              addr_err
);

  localparam int unsigned CW = (CLR_CYCLES > 32'd1) ? $clog2(CLR_CYCLES) : 1;

  lbc_state_e               state_r, state_nxt_s;
  logic [AW-1:0]            addr_r, addr_nxt_s;
  logic [WIDTH-1:0]         lat_d_r, lat_d_nxt_s;
  logic [NWORDS-1:0]        lat_en_r, lat_en_nxt_s;
  logic                     lat_rstb_r, lat_rstb_nxt_s;
  logic                     clr_ack_r, clr_ack_nxt_s;
  logic                     addr_err_r, addr_err_nxt_s;
  logic                     busy_r;
  logic [CW-1:0]            clr_cnt_r, clr_cnt_nxt_s;
  logic                     arb_en_s;
  logic [1:0]               gnt_s;
  logic [LBC_MAX_WORDS-1:0] dec_s;
  logic                     addr_ok_s;

  // Grants are only offered in IDLE with no clear pending and out of reset.
  assign arb_en_s = RSTB && (state_r == IDLE) && !clr_req;

  rr_arb2 u_arb (
    .clk   (CLK),
    .rst_n (RSTB),
    .req   ({req1_valid, req0_valid}),
    .en    (arb_en_s),
    .gnt   (gnt_s)
  );

  assign req0_ready = gnt_s[0];
  assign req1_ready = gnt_s[1];

  assign dec_s     = word_onehot(32'(addr_r), NWORDS);
  assign addr_ok_s = |dec_s;

  // Next state and next values of every registered output.
  always_comb begin
    state_nxt_s    = state_r;
    addr_nxt_s     = addr_r;
    lat_d_nxt_s    = lat_d_r;
    lat_en_nxt_s   = '0;
    lat_rstb_nxt_s = 1'b1;
    clr_ack_nxt_s  = 1'b0;
    addr_err_nxt_s = 1'b0;
    clr_cnt_nxt_s  = clr_cnt_r;
    case (state_r)
      IDLE: begin
        if (clr_req) begin
          state_nxt_s    = CLEAR;
          lat_rstb_nxt_s = 1'b0;
          clr_cnt_nxt_s  = CW'(CLR_CYCLES - 32'd1);
        end else if (gnt_s[0]) begin
          state_nxt_s = SETUP;
          addr_nxt_s  = req0_addr;
          lat_d_nxt_s = req0_data;
        end else if (gnt_s[1]) begin
          state_nxt_s = SETUP;
          addr_nxt_s  = req1_addr;
          lat_d_nxt_s = req1_data;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SETUP: begin
        state_nxt_s    = OPEN;
        lat_en_nxt_s   = dec_s[NWORDS-1:0];
        addr_err_nxt_s = ~addr_ok_s;
      end
      OPEN: begin
        state_nxt_s = HOLD;
      end
      HOLD: begin
        state_nxt_s = IDLE;
      end
      CLEAR: begin
        // The last low cycle of the clear hands over straight to recovery.
        if (clr_cnt_r == '0) begin
          state_nxt_s   = RECOV;
          clr_ack_nxt_s = 1'b1;
        end else begin
          clr_cnt_nxt_s  = clr_cnt_r - CW'(1);
          lat_rstb_nxt_s = 1'b0;
        end
      end
      RECOV: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, capture and output registers; reset keeps the bank cleared.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_r    <= IDLE;
      addr_r     <= '0;
      lat_d_r    <= '0;
      lat_en_r   <= '0;
      lat_rstb_r <= 1'b0;
      clr_ack_r  <= 1'b0;
      addr_err_r <= 1'b0;
      busy_r     <= 1'b0;
      clr_cnt_r  <= '0;
    end else begin
      state_r    <= state_nxt_s;
      addr_r     <= addr_nxt_s;
      lat_d_r    <= lat_d_nxt_s;
      lat_en_r   <= lat_en_nxt_s;
      lat_rstb_r <= lat_rstb_nxt_s;
      clr_ack_r  <= clr_ack_nxt_s;
      addr_err_r <= addr_err_nxt_s;
      busy_r     <= (state_nxt_s != IDLE);
      clr_cnt_r  <= clr_cnt_nxt_s;
    end
  end

  assign lat_en   = lat_en_r;
  assign lat_d    = lat_d_r;
  assign lat_rstb = lat_rstb_r;
  assign clr_ack  = clr_ack_r;
  assign addr_err = addr_err_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_latch_bank_wr_ctrl.sv
// Bench for latch_bank_wr_ctrl: directed scenarios plus random traffic checked
// against a timeline model that schedules each write/clear's visible effects.
module tb_latch_bank_wr_ctrl;

  localparam int NW  = 16;
  localparam int WD  = 8;
  localparam int AWB = 5;
  localparam int CC  = 2;
  localparam int OW  = NW + WD + 4;

  logic           CLK = 1'b0;
  logic           RSTB = 1'b1;
  logic           req0_valid, req1_valid, req0_ready, req1_ready;
  logic [AWB-1:0] req0_addr, req1_addr;
  logic [WD-1:0]  req0_data, req1_data;
  logic           clr_req, clr_ack, lat_rstb, busy, addr_err;
  logic [NW-1:0]  lat_en;
  logic [WD-1:0]  lat_d;

  latch_bank_wr_ctrl #(.NWORDS(NW), .WIDTH(WD), .AW(AWB), .CLR_CYCLES(CC)) dut (
    .CLK(CLK), .RSTB(RSTB),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .clr_req(clr_req), .clr_ack(clr_ack), .lat_en(lat_en), .lat_d(lat_d),
    .lat_rstb(lat_rstb), .busy(busy), .addr_err(addr_err)
  );

  always #5 CLK = ~CLK;

  wire [OW-1:0] obs = {lat_en, lat_d, lat_rstb, clr_ack, addr_err, busy};

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int idle_at = 0;
  int who = -1;
  bit lg = 1'b1;

  // Timeline of scheduled effects, indexed by cycle modulo 16.
  logic [NW-1:0] s_en [16];
  logic [WD-1:0] s_d [16];
  bit s_rlow [16], s_ack [16], s_err [16], s_busy [16], s_dset [16];

  logic [NW-1:0] e_en;
  logic [WD-1:0] e_d;
  logic e_rstb, e_ack, e_err, e_busy, e_r0, e_r1;
  logic [OW-1:0] expv;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      s_en[i] = '0; s_d[i] = '0; s_rlow[i] = 0; s_ack[i] = 0;
      s_err[i] = 0; s_busy[i] = 0; s_dset[i] = 0;
    end
    e_en = '0; e_d = '0; e_rstb = 0; e_ack = 0; e_err = 0; e_busy = 0;
    expv = '0;
    idle_at = 0;
    lg = 1'b1;
  endtask

  // Settle the current inputs and work out who should see ready.
  task automatic prep();
    #1;
    who = -1;
    if (RSTB && cyc >= idle_at && !clr_req) begin
      if (req0_valid && req1_valid) who = lg ? 0 : 1;
      else if (req0_valid) who = 0;
      else if (req1_valid) who = 1;
    end
    e_r0 = (who == 0);
    e_r1 = (who == 1);
  endtask

  // Schedule what the coming edge starts, take the edge, load expectations.
  task automatic tick();
    int t, s;
    logic [AWB-1:0] a;
    logic [WD-1:0] d;
    t = cyc;
    if (RSTB && t >= idle_at) begin
      if (clr_req) begin
        for (int k = 1; k <= CC; k++) begin
          s_rlow[(t + k) % 16] = 1; s_busy[(t + k) % 16] = 1;
        end
        s_ack[(t + CC + 1) % 16] = 1; s_busy[(t + CC + 1) % 16] = 1;
        idle_at = t + CC + 2;
      end else if (who >= 0) begin
        a = (who == 1) ? req1_addr : req0_addr;
        d = (who == 1) ? req1_data : req0_data;
        lg = (who == 1);
        s_dset[(t + 1) % 16] = 1; s_d[(t + 1) % 16] = d;
        for (int k = 1; k <= 3; k++) s_busy[(t + k) % 16] = 1;
        s_en[(t + 2) % 16] = (a < NW) ? (NW'(1) << a) : '0;
        s_err[(t + 2) % 16] = (a >= NW);
        idle_at = t + 4;
      end
    end
    @(posedge CLK);
    #1;
    cyc++;
    if (RSTB) begin
      s = cyc % 16;
      e_en = s_en[s];
      if (s_dset[s]) e_d = s_d[s];
      e_rstb = !s_rlow[s]; e_ack = s_ack[s]; e_err = s_err[s]; e_busy = s_busy[s];
      s_en[s] = '0; s_rlow[s] = 0; s_ack[s] = 0; s_err[s] = 0; s_busy[s] = 0; s_dset[s] = 0;
    end else begin
      e_en = '0; e_d = '0; e_rstb = 0; e_ack = 0; e_err = 0; e_busy = 0;
    end
    expv = {e_en, e_d, e_rstb, e_ack, e_err, e_busy};
  endtask

  task automatic apply_reset();
    req0_valid = 0; req1_valid = 0; clr_req = 0;
    RSTB = 0;
    model_reset();
    prep(); tick();
    RSTB = 1;
    prep(); tick();
  endtask

  task automatic test_reset();
    req0_valid = 1; req1_valid = 1; clr_req = 0;
    req0_addr = 5'd1; req1_addr = 5'd2; req0_data = 8'h11; req1_data = 8'h22;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      prep();
      n_cmp++;
      if ({req0_ready, req1_ready, obs} !== '0)
        begin n_fail++; $display("FAIL reset_state: got %h expected 0", {req0_ready, req1_ready, obs}); end
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    RSTB = 1;
    prep();
    n_cmp++;
    if (lat_rstb !== 1'b0) begin n_fail++; $display("FAIL rstb_before_edge: got %b expected 0", lat_rstb); end
    tick();
    n_cmp++;
    if (obs !== expv || lat_rstb !== 1'b1)
      begin n_fail++; $display("FAIL rstb_release: got %h expected %h", obs, expv); end
  endtask

  task automatic test_single_write();
    int n;
    req0_valid = 1; req0_addr = 5'd5; req0_data = 8'hA5; req1_valid = 0; clr_req = 0;
    prep();
    n_cmp++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
      begin n_fail++; $display("FAIL single_ready: got %b%b expected 10", req0_ready, req1_ready); end
    n = cyc;
    tick();
    req0_valid = 0;
    for (int k = 1; k <= 4; k++) begin
      n_cmp++;
      if (obs !== expv) begin n_fail++; $display("FAIL single_model k=%0d: got %h expected %h", k, obs, expv); end
      n_cmp++;
      if ((k == 1 && (lat_d !== 8'hA5 || lat_en !== '0)) ||
          (k == 2 && (lat_en !== 16'h0020 || lat_d !== 8'hA5)) ||
          (k == 3 && (lat_en !== '0 || lat_d !== 8'hA5)) ||
          (k == 4 && (busy !== 1'b0 || lat_en !== '0)))
        begin n_fail++; $display("FAIL single_phase k=%0d: got en=%h d=%h busy=%b", k, lat_en, lat_d, busy); end
      req0_valid = (k == 4);
      prep();
      n_cmp++;
      if ({req0_ready, req1_ready} !== {e_r0, e_r1} || (k == 4 && req0_ready !== 1'b1))
        begin n_fail++; $display("FAIL single_rdy k=%0d: got %b%b expected %b%b", k, req0_ready, req1_ready, e_r0, e_r1); end
      tick();
      req0_valid = 0;
    end
    for (int i = 0; i < 5; i++) begin prep(); tick(); end
    if (cyc - n < 4) $display("note: short window");
  endtask

  task automatic test_back_to_back();
    int np, last;
    apply_reset();
    req0_valid = 1; req1_valid = 1; req0_addr = 5'd1; req1_addr = 5'd2;
    np = 0; last = 0;
    for (int i = 0; i < 40; i++) begin
      req0_data = 8'($urandom); req1_data = 8'($urandom);
      prep();
      n_cmp++;
      if ({req0_ready, req1_ready} !== {e_r0, e_r1})
        begin n_fail++; $display("FAIL b2b_rdy: got %b%b expected %b%b", req0_ready, req1_ready, e_r0, e_r1); end
      tick();
      n_cmp++;
      if (obs !== expv) begin n_fail++; $display("FAIL b2b_model: got %h expected %h", obs, expv); end
      if (lat_en !== '0) begin
        n_cmp++;
        if (lat_en !== ((np % 2 == 0) ? 16'h0002 : 16'h0004) || (np > 0 && cyc - last != 4))
          begin n_fail++; $display("FAIL b2b_alt: got en=%h gap=%0d pulse=%0d", lat_en, cyc - last, np); end
        np++; last = cyc;
      end
    end
    n_cmp++;
    if (np != 10) begin n_fail++; $display("FAIL b2b_count: got %0d expected 10", np); end
    req0_valid = 0; req1_valid = 0;
    for (int i = 0; i < 5; i++) begin prep(); tick(); end
  endtask

  task automatic test_clear_mid_write();
    int n, rlow, acks, hs1;
    apply_reset();
    req0_valid = 1; req0_addr = 5'd3; req0_data = 8'h5A; req1_valid = 0; clr_req = 0;
    prep(); n = cyc; tick();
    req0_valid = 0;
    req1_valid = 1; req1_addr = 5'd9; req1_data = 8'h3C;
    rlow = 0; acks = 0; hs1 = -1;
    for (int i = 0; i < 20; i++) begin
      n_cmp++;
      if (obs !== expv) begin n_fail++; $display("FAIL clr_model k=%0d: got %h expected %h", cyc - n, obs, expv); end
      if (cyc - n == 2) begin
        n_cmp++;
        if (lat_en !== 16'h0008) begin n_fail++; $display("FAIL clr_open_en: got %h expected 0008", lat_en); end
        clr_req = 1;
      end
      if (lat_rstb === 1'b0) rlow++;
      if (clr_ack === 1'b1) begin acks++; clr_req = 0; end
      prep();
      n_cmp++;
      if ({req0_ready, req1_ready} !== {e_r0, e_r1})
        begin n_fail++; $display("FAIL clr_rdy: got %b%b expected %b%b", req0_ready, req1_ready, e_r0, e_r1); end
      if (req1_valid && req1_ready) hs1 = cyc;
      tick();
      if (hs1 >= 0) req1_valid = 0;
    end
    n_cmp++;
    if (rlow != CC || acks != 1 || hs1 != n + 8)
      begin n_fail++; $display("FAIL clr_summary: got rlow=%0d ack=%0d hs=%0d expected %0d 1 %0d", rlow, acks, hs1 - n, CC, 8); end
  endtask

  task automatic test_out_of_range();
    int n, errs;
    req1_valid = 1; req1_addr = 5'd20; req1_data = 8'($urandom); req0_valid = 0; clr_req = 0;
    for (int i = 0; i < 4; i++) begin prep(); tick(); end
    req1_valid = 0;
    for (int i = 0; i < 2; i++) begin prep(); tick(); end
    req1_valid = 1;
    prep();
    n_cmp++;
    if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL oor_ready: got %b expected 1", req1_ready); end
    n = cyc; tick();
    req1_valid = 0; errs = 0;
    for (int k = 1; k <= 5; k++) begin
      n_cmp++;
      if (obs !== expv || lat_en !== '0 || addr_err !== (k == 2) || (k == 4 && busy !== 1'b0))
        begin n_fail++; $display("FAIL oor_phase k=%0d: got %h expected %h", k, obs, expv); end
      if (addr_err === 1'b1) errs++;
      prep(); tick();
    end
    n_cmp++;
    if (errs != 1) begin n_fail++; $display("FAIL oor_errcount: got %0d expected 1", errs); end
  endtask

  task automatic test_reset_mid_write();
    int pulses;
    apply_reset();
    req0_valid = 1; req0_addr = 5'd7; req0_data = 8'hC3; req1_valid = 0; clr_req = 0;
    prep(); tick();
    req0_valid = 0;
    RSTB = 0;
    #1;
    n_cmp++;
    if (obs !== '0) begin n_fail++; $display("FAIL async_reset: got %h expected 0", obs); end
    model_reset();
    for (int i = 0; i < 2; i++) begin prep(); tick(); end
    RSTB = 1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      prep(); tick();
      n_cmp++;
      if (obs !== expv) begin n_fail++; $display("FAIL post_reset: got %h expected %h", obs, expv); end
      if (lat_en !== '0) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin n_fail++; $display("FAIL post_reset_en: got %0d pulses expected 0", pulses); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      req0_valid = ($urandom_range(0, 9) < 6);
      req1_valid = ($urandom_range(0, 9) < 6);
      req0_addr = 5'($urandom_range(0, 19));
      req1_addr = 5'($urandom_range(0, 19));
      req0_data = 8'($urandom);
      req1_data = 8'($urandom);
      clr_req = ($urandom_range(0, 11) == 0);
      prep();
      n_cmp++;
      if ({req0_ready, req1_ready} !== {e_r0, e_r1})
        begin n_fail++; $display("FAIL rand_rdy: got %b%b expected %b%b", req0_ready, req1_ready, e_r0, e_r1); end
      tick();
      n_cmp++;
      if (obs !== expv) begin n_fail++; $display("FAIL rand_model: got %h expected %h", obs, expv); end
      n_cmp++;
      if ($countones(lat_en) > 1 || (lat_en !== '0 && lat_rstb !== 1'b1))
        begin n_fail++; $display("FAIL rand_enable_rules: got en=%h rstb=%b", lat_en, lat_rstb); end
    end
  endtask

  initial begin
    req0_valid = 0; req1_valid = 0; clr_req = 0;
    req0_addr = '0; req1_addr = '0; req0_data = '0; req1_data = '0;
    #2;
    RSTB = 0;
    test_reset();
    test_single_write();
    test_back_to_back();
    test_clear_mid_write();
    test_out_of_range();
    test_reset_mid_write();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
